// File: rtl/mod_add_ctrl.sv
// mod_add_ctrl
// Modular add/subtract controller. Computes (a+b) mod m or (a-b) mod m by
// issuing one or two operations to an external multi-precision adder over
// its start/done handshake. This block is the initiator of that handshake.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start, op_sub           request (accepted only while busy=0) and mode
//   in_a, in_b, in_m        operands and modulus, sampled with start
//   result, done, error     modular result, completion pulse, watchdog flag
//   busy                    high from the cycle after an accepted start
//                           through the done cycle
//   add_start               one-cycle start pulse to the adder
//   add_subtract, add_shift adder mode (shift tied low)
//   add_in_a, add_in_b      adder operands
//   add_result, add_done    adder result (N+1 bits) and level done
//   state_dbg               current FSM state encoding, for observation
//
// Handshakes:
//   Request side: a request is transferred in a cycle where start=1 and
//   busy=0; start while busy=1 is dropped. The answer is the single cycle
//   with done=1; result and error stay valid until the next accepted start.
//   Adder side: add_start is high for exactly one cycle; add_in_a, add_in_b
//   and add_subtract hold steady from that cycle until completion. Completion
//   is a rising edge of add_done observed while waiting, so a done level
//   left high by a previous operation is never taken as completion.
module mod_add_ctrl #(
    parameter int N           = 514,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         error,
    output logic         add_start,
    output logic         add_subtract,
    output logic         add_shift,
    output logic [N-1:0] add_in_a,
    output logic [N-1:0] add_in_b,
    input  logic [N:0]   add_result,
    input  logic         add_done,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam int              WW        = $clog2(WDOG_CYCLES);
    localparam logic [WW-1:0]   WDOG_LAST = WW'(WDOG_CYCLES - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  m_q, m_d;
    logic          sub_q, sub_d;
    logic [N-1:0]  r1_q, r1_d;          // low bits of first adder result
    logic [N-1:0]  result_q, result_d;
    logic          error_q, error_d;
    logic [N-1:0]  add_a_q, add_a_d;
    logic [N-1:0]  add_b_q, add_b_d;
    logic          add_sub_q, add_sub_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          add_done_q;
    logic          complete;

    assign complete = add_done && !add_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m_q        <= '0;
            sub_q      <= 1'b0;
            r1_q       <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_sub_q  <= 1'b0;
            wdog_q     <= '0;
            add_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            sub_q      <= sub_d;
            r1_q       <= r1_d;
            result_q   <= result_d;
            error_q    <= error_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_sub_q  <= add_sub_d;
            wdog_q     <= wdog_d;
            add_done_q <= add_done;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        sub_d     = sub_q;
        r1_d      = r1_q;
        result_d  = result_q;
        error_d   = error_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;
        wdog_d    = wdog_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d       = in_m;
                    sub_d     = op_sub;
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_sub_d = op_sub;
                    error_d   = 1'b0;
                    state_d   = ISSUE1;
                end
            end
            ISSUE1: begin
                wdog_d  = '0;
                state_d = WAIT1;
            end
            WAIT1: begin
                if (complete) begin
                    r1_d = add_result[N-1:0];
                    // Addition always needs the trial subtraction of m; a
                    // subtraction only needs m added back when it went negative.
                    if (!sub_q || add_result[N]) begin
                        add_a_d   = add_result[N-1:0];
                        add_b_d   = m_q;
                        add_sub_d = !sub_q;
                        state_d   = ISSUE2;
                    end else begin
                        result_d = add_result[N-1:0];
                        state_d  = FIN;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    error_d  = 1'b1;
                    result_d = '0;
                    state_d  = FIN;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ISSUE2: begin
                wdog_d  = '0;
                state_d = WAIT2;
            end
            WAIT2: begin
                if (complete) begin
                    // A negative trial subtraction means the sum was already < m.
                    if (!sub_q && add_result[N]) begin
                        result_d = r1_q;
                    end else begin
                        result_d = add_result[N-1:0];
                    end
                    state_d = FIN;
                end else if (wdog_q == WDOG_LAST) begin
                    error_d  = 1'b1;
                    result_d = '0;
                    state_d  = FIN;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result       = result_q;
    assign error        = error_q;
    assign done         = (state_q == FIN);
    assign busy         = (state_q != IDLE);
    assign add_start    = (state_q == ISSUE1) || (state_q == ISSUE2);
    assign add_subtract = add_sub_q;
    assign add_shift    = 1'b0;
    assign add_in_a     = add_a_q;
    assign add_in_b     = add_b_q;
    assign state_dbg    = state_q;

endmodule
